// File: rtl/word_narrow_serializer.sv
// Narrowing serializer: 32-bit words in, 16-bit beats out.
// Words with a zero upper half may go as one zext-tagged beat.
module word_narrow_serializer #(
  parameter bit COMPRESS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_half,
  output logic        out_zext,
  output logic        out_last,
  output logic [15:0] word_cnt,
  output logic [15:0] zext_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        cmp_q, cmp_d;
  logic        alive_q;
  logic        valid_q, valid_d;
  logic [15:0] half_q, half_d;
  logic        zext_q, zext_d;
  logic        last_q, last_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] zcnt_q, zcnt_d;

  logic xfer;
  logic done;
  logic acc;
  logic cmp_in;

  assign xfer   = valid_q && out_ready;
  assign done   = xfer && last_q;
  // alive_q keeps in_ready low during reset and the edge it lifts
  assign in_ready = alive_q && ((state_q == EMPTY) || done);
  assign acc    = in_valid && in_ready;
  assign cmp_in = COMPRESS_EN && (in_word[31:16] == 16'h0000);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cmp_d   = cmp_q;
    valid_d = valid_q;
    half_d  = half_q;
    zext_d  = zext_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    zcnt_d  = zcnt_q;

    unique case (state_q)
      LO: begin
        if (xfer && !cmp_q) begin
          state_d = HI;
          half_d  = word_q[31:16];
          zext_d  = 1'b0;
          last_d  = 1'b1;
        end
      end
      HI: ;
      default: ;
    endcase

    if (done) begin
      wcnt_d = wcnt_q + 16'd1;
      if (cmp_q && (zcnt_q != 16'hFFFF))
        zcnt_d = zcnt_q + 16'd1;
      state_d = EMPTY;
      valid_d = 1'b0;
      half_d  = 16'h0000;
      zext_d  = 1'b0;
      last_d  = 1'b0;
    end

    if (acc) begin
      state_d = LO;
      word_d  = in_word;
      cmp_d   = cmp_in;
      valid_d = 1'b1;
      half_d  = in_word[15:0];
      zext_d  = cmp_in;
      last_d  = cmp_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      word_q  <= 32'h0;
      cmp_q   <= 1'b0;
      alive_q <= 1'b0;
      valid_q <= 1'b0;
      half_q  <= 16'h0;
      zext_q  <= 1'b0;
      last_q  <= 1'b0;
      wcnt_q  <= 16'h0;
      zcnt_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cmp_q   <= cmp_d;
      alive_q <= 1'b1;
      valid_q <= valid_d;
      half_q  <= half_d;
      zext_q  <= zext_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      zcnt_q  <= zcnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_half  = half_q;
  assign out_zext  = zext_q;
  assign out_last  = last_q;
  assign word_cnt  = wcnt_q;
  assign zext_cnt  = zcnt_q;

endmodule

// File: tb/tb_word_narrow_serializer.sv
// Directed bench for word_narrow_serializer.
// Second instance runs with compression disabled.
module tb_word_narrow_serializer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_valid0;
  logic [31:0] in_word;
  logic        out_ready;

  logic        in_ready, out_valid, out_zext, out_last;
  logic [15:0] out_half, word_cnt, zext_cnt;
  logic        in_ready0, out_valid0, out_zext0, out_last0;
  logic [15:0] out_half0, word_cnt0, zext_cnt0;

  int n_assert;
  int n_fail;

  word_narrow_serializer #(.COMPRESS_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_half(out_half),
    .out_zext(out_zext), .out_last(out_last),
    .word_cnt(word_cnt), .zext_cnt(zext_cnt)
  );

  word_narrow_serializer #(.COMPRESS_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_word(in_word),
    .out_valid(out_valid0), .out_ready(out_ready), .out_half(out_half0),
    .out_zext(out_zext0), .out_last(out_last0),
    .word_cnt(word_cnt0), .zext_cnt(zext_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [15:0] h,
                      input logic z, input logic l);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_half"}, {16'b0, out_half}, {16'b0, h});
    chk({tag, "_zext"}, {31'b0, out_zext}, {31'b0, z});
    chk({tag, "_last"}, {31'b0, out_last}, {31'b0, l});
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_valid0 = 1'b0;
    in_word = 32'h0;
    out_ready = 1'b1;

    // reset state
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_wcnt", {16'b0, word_cnt}, 32'd0);
    chk("rst_zcnt", {16'b0, zext_cnt}, 32'd0);
    tick();
    chk("rst_ready_edge", {31'b0, in_ready}, 32'd0);
    #3 reset_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // compressed word
    in_word = 32'h00007B95;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("cmp", 16'h7B95, 1'b1, 1'b1);
    tick();
    chk("cmp_done_valid", {31'b0, out_valid}, 32'd0);
    chk("cmp_wcnt", {16'b0, word_cnt}, 32'd1);
    chk("cmp_zcnt", {16'b0, zext_cnt}, 32'd1);

    // two-beat word
    in_word = 32'h0001FB95;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("two_lo", 16'hFB95, 1'b0, 1'b0);
    tick();
    beat("two_hi", 16'h0001, 1'b0, 1'b1);
    tick();
    chk("two_done_valid", {31'b0, out_valid}, 32'd0);
    chk("two_wcnt", {16'b0, word_cnt}, 32'd2);
    chk("two_zcnt", {16'b0, zext_cnt}, 32'd1);

    // compression disabled instance
    in_word = 32'h00007B95;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    chk("nc_lo_half", {16'b0, out_half0}, 32'h7B95);
    chk("nc_lo_zext", {31'b0, out_zext0}, 32'd0);
    chk("nc_lo_last", {31'b0, out_last0}, 32'd0);
    tick();
    chk("nc_hi_half", {16'b0, out_half0}, 32'h0000);
    chk("nc_hi_last", {31'b0, out_last0}, 32'd1);
    tick();
    chk("nc_done_valid", {31'b0, out_valid0}, 32'd0);
    chk("nc_wcnt", {16'b0, word_cnt0}, 32'd1);
    chk("nc_zcnt", {16'b0, zext_cnt0}, 32'd0);

    // backpressure on the low beat
    in_word = 32'hFB957B95;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat("bp_hold", 16'h7B95, 1'b0, 1'b0);
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    beat("bp_hi", 16'hFB95, 1'b0, 1'b1);
    tick();
    chk("bp_done_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_wcnt", {16'b0, word_cnt}, 32'd3);

    // back-to-back stream
    in_word = 32'h00001111;
    in_valid = 1'b1;
    tick();
    in_word = 32'h00002222;
    #1;
    chk("b2b_ready", {31'b0, in_ready}, 32'd1);
    beat("b2b_1", 16'h1111, 1'b1, 1'b1);
    tick();
    in_word = 32'h33334444;
    beat("b2b_2", 16'h2222, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    beat("b2b_3", 16'h4444, 1'b0, 1'b0);
    tick();
    beat("b2b_4", 16'h3333, 1'b0, 1'b1);
    tick();
    chk("b2b_done_valid", {31'b0, out_valid}, 32'd0);
    chk("b2b_wcnt", {16'b0, word_cnt}, 32'd6);
    chk("b2b_zcnt", {16'b0, zext_cnt}, 32'd3);

    // upper nonzero, lower zero
    in_word = 32'h00050000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("lz_lo", 16'h0000, 1'b0, 1'b0);
    tick();
    beat("lz_hi", 16'h0005, 1'b0, 1'b1);
    tick();

    // reset during the high beat
    in_word = 32'hABCD1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("mr_lo", 16'h1234, 1'b0, 1'b0);
    tick();
    beat("mr_hi", 16'hABCD, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_half", {16'b0, out_half}, 32'd0);
    chk("mr_ready", {31'b0, in_ready}, 32'd0);
    chk("mr_wcnt", {16'b0, word_cnt}, 32'd0);
    chk("mr_zcnt", {16'b0, zext_cnt}, 32'd0);
    tick();
    chk("mr_valid_edge", {31'b0, out_valid}, 32'd0);
    #3 reset_n = 1'b1;
    tick();
    chk("mr_after_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_after_ready", {31'b0, in_ready}, 32'd1);
    in_word = 32'h00000005;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("mr_next", 16'h0005, 1'b1, 1'b1);
    tick();
    chk("mr_next_wcnt", {16'b0, word_cnt}, 32'd1);
    chk("mr_next_zcnt", {16'b0, zext_cnt}, 32'd1);

    // counter boundaries, zero words streamed
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    in_word = 32'h00000000;
    in_valid = 1'b1;
    tick();
    beat("zero_word", 16'h0000, 1'b1, 1'b1);
    repeat (65534) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_zcnt", {16'b0, zext_cnt}, 32'h0000FFFF);
    chk("sat_wcnt", {16'b0, word_cnt}, 32'h0000FFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("sat_zcnt_hold", {16'b0, zext_cnt}, 32'h0000FFFF);
    chk("wrap_wcnt", {16'b0, word_cnt}, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/word_narrow_serializer.md
# word_narrow_serializer

Narrowing serializer for the 32-bit MIPS datapath. It is the inverse of the 16→32 zero-extender. It accepts 32-bit words over a valid/ready handshake and emits them as 16-bit halfwords on a narrow bus. When the upper half of a word is all zeros, it sends only the low half and tags it so the far end zero-extends it back to 32 bits. It sits between the 32-bit core side and a 16-bit link or memory port.

## Interface
- COMPRESS_EN, 1, 1 = words with upper half 0x0000 are sent as a single zext-tagged beat; 0 = every word is sent as two beats.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts in_word this cycle.
- in_word  input  32  word to serialize.
- out_valid  output  1  out_half is valid.
- out_ready  input  1  downstream accepts the beat.
- out_half  output  16  halfword beat.
- out_zext  output  1  beat is a complete word; the receiver zero-extends it to 32 bits.
- out_last  output  1  final beat of the current word.
- word_cnt  output  16  words fully sent; wraps at 0xFFFF→0x0000.
- zext_cnt  output  16  words sent compressed; saturates at 0xFFFF.

## Operation
- **Input handshake:** a word is accepted when in_valid && in_ready.
- **Output handshake:** a beat is transferred when out_valid && out_ready.
- **Holding register:** word_q holds the accepted word. cmp_q = COMPRESS_EN && (in_word[31:16] == 0), captured together with the word.
- **FSM states:** EMPTY, LO, HI.
  - EMPTY: out_valid=0. Accepting a word → LO.
  - LO: out_half=word_q[15:0], out_zext=cmp_q, out_last=cmp_q.
    - Transfer with cmp_q=1 → word done.
    - Transfer with cmp_q=0 → HI.
  - HI: out_half=word_q[31:16], out_zext=0, out_last=1. Transfer → word done.
- **Word done:** if a new word is accepted in the same cycle → LO with the new word; otherwise → EMPTY.
- **in_ready:** (state==EMPTY) || (out_valid && out_ready && out_last). This allows back-to-back words with no bubble.
- **Stability under backpressure:** while out_valid && !out_ready, out_half, out_zext and out_last hold stable. No beat is ever dropped or duplicated.
- **Beat order:** low half always first, high half second.
- **Counters:**
  - word_cnt increments by 1 on every word done.
  - zext_cnt increments on every word done with cmp_q=1, unless it is already 0xFFFF.
- **Zero-word cases:**
  - in_word == 0x00000000 with COMPRESS_EN=1 → one beat 0x0000, zext=1.
  - Upper half nonzero and lower half zero → two beats, the first being 0x0000.
- **Reset:** reset_n low at any time, including mid-word, immediately clears everything:
  - state=EMPTY, word_q=0, cmp_q=0, counters=0.
  - out_valid=0, out_half=0, out_zext=0, out_last=0, in_ready=0 while reset_n is low.
  - A partially sent word is discarded. in_ready goes to 1 on the first clock edge after reset_n deasserts.

## Timing
- **Latency:** word accepted at edge N → first beat valid from edge N (registered, visible in cycle N+1).
- **Throughput with out_ready held high:**
  - Compressed words: 1 word/cycle.
  - Uncompressed words: 1 word per 2 cycles.
- **Counter timing:** counters update on the edge where the out_last beat transfers and are visible the following cycle.
- **Combinational path:** in_ready depends combinationally on out_ready, the only such path. Every other output is registered or decoded from state only.
- **Simultaneous events:**
  - Final-beat transfer plus new-word acceptance in the same cycle: both take effect on the same edge.
  - in_valid asserted while in_ready=0: ignored. The source must hold in_word.

## Test plan
- **Compressed word:** after reset, send 0x00007B95 with out_ready=1 → one beat: out_half=0x7B95, out_zext=1, out_last=1. Then word_cnt=1, zext_cnt=1.
- **Two-beat word:** send 0x0001FB95 → beat 1: 0xFB95 with zext=0, last=0; beat 2: 0x0001 with zext=0, last=1. Then word_cnt=1, zext_cnt=0. Repeat with COMPRESS_EN=0 and 0x00007B95 → beats 0x7B95 then 0x0000.
- **Backpressure:** out_ready=0 for 5 cycles during beat LO of 0xFB957B95 → out_half held at 0x7B95 and in_ready=0 throughout. After release, beat 0xFB95 follows with no beats lost or duplicated.
- **Back-to-back stream:** in_valid held high with 0x00001111, 0x00002222, 0x33334444 and out_ready=1 → beats 0x1111, 0x2222, 0x4444, 0x3333 on 4 consecutive cycles, with no gap cycles.
- **Reset mid-word:** pulse reset_n low during the HI beat of 0xABCD1234 → out_valid=0 and counters=0 immediately, with no 0xABCD beat emitted after reset. The next word, 0x00000005, is sent correctly.
- **Counter boundaries:** preload via 65535 compressed words → zext_cnt=0xFFFF. One more compressed word → zext_cnt stays 0xFFFF and word_cnt wraps to 0x0000.
